// File: rtl/fifo_serializer.sv
// Show-ahead FIFO consumer that emits each wide word as RATIO narrow chunks, LSB first.
// Define FIFO_SERIALIZER_PREFETCH_EN to add a one-word holding register for gapless output.
module fifo_serializer #(
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = 4,
  parameter int LOG_RATIO = 2,
  parameter int IN_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_next_read,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 idle
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IN_WIDTH-1:0]   r_shift;
  logic [IN_WIDTH-1:0]   w_shift_nxt;
  logic [OUT_WIDTH-1:0]  r_data;
  logic [OUT_WIDTH-1:0]  w_data_nxt;
  logic [LOG_RATIO-1:0]  r_idx;
  logic [LOG_RATIO-1:0]  w_idx_nxt;

  logic                  w_xfer;
  logic                  w_last;
  logic                  w_idle_load;
  logic                  w_hold_cap;
  logic                  w_hold_use;
  logic                  w_hold_v;
  logic [IN_WIDTH-1:0]   w_hold;
  logic [IN_WIDTH-1:0]   w_load_word;

`ifdef FIFO_SERIALIZER_PREFETCH_EN
  logic [IN_WIDTH-1:0]   r_hold;
  logic                  r_hold_v;

  assign w_hold_cap = rst && (r_state == S_SEND) &&
                      !r_hold_v && !fifo_empty;
  assign w_hold     = r_hold;
  assign w_hold_v   = r_hold_v;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold   <= '0;
      r_hold_v <= 1'b0;
    end else if (w_hold_cap) begin
      r_hold   <= fifo_data;
      r_hold_v <= 1'b1;
    end else if (w_hold_use) begin
      r_hold_v <= 1'b0;
    end
  end
`else
  assign w_hold_cap = 1'b0;
  assign w_hold     = '0;
  assign w_hold_v   = 1'b0;
`endif

  assign w_xfer      = (r_state == S_SEND) && ready_in;
  assign w_last      = (r_idx == LOG_RATIO'(RATIO - 1));
  assign w_idle_load = rst && (r_state == S_IDLE) &&
                       !w_hold_v && !fifo_empty;
  assign w_load_word = w_hold_v ? w_hold : fifo_data;

  assign fifo_next_read = w_idle_load | w_hold_cap;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_idx_nxt   = r_idx;
    w_hold_use  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_hold_v || w_idle_load) begin
          w_hold_use  = w_hold_v;
          w_state_nxt = S_SEND;
          w_shift_nxt = w_load_word;
          w_data_nxt  = w_load_word[OUT_WIDTH-1:0];
          w_idx_nxt   = '0;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          unique case (1'b1)
            !w_last: begin
              w_shift_nxt = r_shift >> OUT_WIDTH;
              w_data_nxt  = r_shift[2*OUT_WIDTH-1:OUT_WIDTH];
              w_idx_nxt   = r_idx + 1'b1;
            end
            w_last && w_hold_v: begin
              // back-to-back word: restart at chunk 0 without a gap
              w_hold_use  = 1'b1;
              w_shift_nxt = w_hold;
              w_data_nxt  = w_hold[OUT_WIDTH-1:0];
              w_idx_nxt   = '0;
            end
            w_last && !w_hold_v: begin
              w_state_nxt = S_IDLE;
              w_idx_nxt   = '0;
            end
            default: ;
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_data  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign data_out  = r_data;
  assign valid_out = (r_state == S_SEND);
  assign idle      = (r_state == S_IDLE) && !w_hold_v;

endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench for fifo_serializer: FIFO model feeds words, chunks checked in order.
// Run with or without FIFO_SERIALIZER_PREFETCH_EN; gap expectations follow the macro.
module tb_fifo_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_next_read;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        idle;

  fifo_serializer #(
    .OUT_WIDTH(8),
    .RATIO(4),
    .LOG_RATIO(2),
    .IN_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_data(fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_next_read(fifo_next_read),
    .data_out(data_out),
    .valid_out(valid_out),
    .ready_in(ready_in),
    .idle(idle)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_out = 0;
  int          n_pop = 0;
  logic [31:0] q[$];
  logic [7:0]  sb[$];
  logic        rst_v = 1'b0;
  logic        rdy_v = 1'b0;
  logic        gate_v = 1'b0;
  logic        hold_chk = 1'b0;
  logic [7:0]  hold_d = '0;
  logic [31:0] vt = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycle();
    logic [31:0] w;
    @(negedge clk);
    rst        = rst_v;
    ready_in   = rdy_v;
    fifo_empty = gate_v || (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 32'h0;
    #1;
    if (hold_chk) begin
      chk("hold_data", {24'h0, data_out}, {24'h0, hold_d});
      chk("hold_valid", {31'h0, valid_out}, 32'h1);
    end
    if (!rst_v) begin
      chk("rst_pop", {31'h0, fifo_next_read}, 32'h0);
      sb.delete();
      hold_chk = 1'b0;
    end else begin
      if (fifo_next_read) begin
        chk("pop_nonempty", {31'h0, fifo_empty}, 32'h0);
        if (q.size() != 0) begin
          w = q.pop_front();
          n_pop++;
          for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
        end
      end
      if (valid_out && ready_in) begin
        n_out++;
        if (sb.size() == 0) chk("unexpected_out", 32'h1, 32'h0);
        else chk("data", {24'h0, data_out}, {24'h0, sb.pop_front()});
      end
      hold_chk = valid_out && !ready_in;
      hold_d   = data_out;
    end
    vt = {vt[30:0], valid_out};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr();
    n_out = 0;
    n_pop = 0;
    vt    = '0;
  endtask

  initial begin
    logic [6:0] pat;
    int         k;

    rst_v = 1'b0;
    run(3);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_idle", {31'h0, idle}, 32'h1);
    chk("rst_data", {24'h0, data_out}, 32'h0);
    rst_v = 1'b1;
    run(2);

    // single word
    clr();
    rdy_v = 1'b1;
    q.push_back(32'hDDCCBBAA);
    run(6);
    chk("t1_pops", n_pop, 1);
    chk("t1_outs", n_out, 4);
    chk("t1_trace", {26'h0, vt[5:0]}, 32'b011110);
    chk("t1_idle", {31'h0, idle}, 32'h1);

    // backpressure
    clr();
    q.push_back(32'hDDCCBBAA);
    pat = 7'b1011001;
    cycle();
    for (int i = 6; i >= 0; i--) begin
      rdy_v = pat[i];
      cycle();
    end
    rdy_v = 1'b1;
    run(2);
    chk("t2_outs", n_out, 4);
    chk("t2_sb_empty", sb.size(), 0);

    // back-to-back words
    clr();
    q.push_back(32'h03020100);
    q.push_back(32'h07060504);
    run(11);
    chk("t3_outs", n_out, 8);
`ifdef FIFO_SERIALIZER_PREFETCH_EN
    chk("t3_trace", {21'h0, vt[10:0]}, 32'b01111111100);
`else
    chk("t3_trace", {21'h0, vt[10:0]}, 32'b01111011110);
`endif

    // empty FIFO
    gate_v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("t4_pop", {31'h0, fifo_next_read}, 32'h0);
      chk("t4_valid", {31'h0, valid_out}, 32'h0);
      chk("t4_idle", {31'h0, idle}, 32'h1);
    end
    gate_v = 1'b0;

    // reset mid-word
    clr();
    q.push_back(32'hDDCCBBAA);
    run(3);
    chk("t5_pre_outs", n_out, 2);
    rdy_v = 1'b0;
    rst_v = 1'b0;
    run(2);
    chk("t5_rst_valid", {31'h0, valid_out}, 32'h0);
    chk("t5_rst_idle", {31'h0, idle}, 32'h1);
    rst_v = 1'b1;
    rdy_v = 1'b1;
    run(1);
    clr();
    q.push_back(32'h44332211);
    run(6);
    chk("t5_outs", n_out, 4);
    chk("t5_pops", n_pop, 1);

    // random pop protocol
    for (int i = 0; i < 1000; i++) begin
      if (q.size() < 4 && $urandom_range(0, 1) == 1) q.push_back($urandom);
      gate_v = ($urandom_range(0, 2) == 0);
      rdy_v  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    gate_v = 1'b0;
    rdy_v  = 1'b1;
    k = 0;
    while ((q.size() != 0 || sb.size() != 0 || !idle) && k < 200) begin
      cycle();
      k++;
    end
    chk("t6_drain_timeout", {31'h0, k >= 200}, 32'h0);
    chk("t6_q_empty", q.size(), 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
